// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// fb_scanout : VRAM line prefetch, 1/2/4/8 bpp unpack, 1x/2x/4x scale, RGB888
// Rev 1.0
// ============================================================================
module fb_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        cx,
  input  logic [9:0]        cy,
  input  logic              cfg_we,
  input  logic [31:0]       cfg_d,
  output logic [31:0]       cfg_q,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_a,
  input  logic              mem_ready,
  input  logic [WORD_W-1:0] mem_spo,
  output logic [23:0]       pix_rgb,
  output logic              underrun
);

  localparam int WSH   = $clog2(WORD_W);
  localparam int SHW   = WSH + 3;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [9:0]     HA   = 10'(H_ACTIVE);
  localparam logic [9:0]     VA   = 10'(V_ACTIVE);
  localparam logic [9:0]     VL   = 10'(V_TOTAL - 1);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

  function automatic logic [1:0] scale_sh(input logic [1:0] s);
    return (s == 2'd0) ? 2'd0 : (s == 2'd1) ? 2'd1 : 2'd2;
  endfunction

  logic [31:0]       r_pend, r_act;
  state_t            r_state;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_remain;
  logic [WORD_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W:0]    r_wp, r_rp;
  logic              r_have, r_stall;
  logic [WORD_W-1:0] r_word;
  logic [WSH-1:0]    r_idx;
  logic [1:0]        r_rep;
  logic [23:0]       r_pix;
  logic              r_underrun;

  // The frame-edge trigger must already see the freshly shadowed config.
  logic              w_frame_edge;
  logic [31:0]       w_cfg;
  logic [9:0]        w_t;
  logic [1:0]        w_sh_n;
  logic [31:0]       w_wpl_n;
  logic [9:0]        w_row;
  logic [ADDR_W-1:0] w_load_addr;
  logic              w_load;

  assign w_frame_edge = (cx == HA) && (cy == VL);
  assign w_cfg        = w_frame_edge ? r_pend : r_act;
  assign w_t          = (cy == VL) ? 10'd0 : cy + 10'd1;
  assign w_sh_n       = scale_sh(w_cfg[4:3]);
  assign w_wpl_n      = (32'(H_ACTIVE) << w_cfg[2:1]) >> (32'(w_sh_n) + WSH);
  assign w_row        = w_t >> w_sh_n;
  assign w_load_addr  = w_cfg[16 +: ADDR_W] + ADDR_W'(32'(w_row) * w_wpl_n);
  assign w_load       = (cx == HA) && w_cfg[0] && (w_t < VA);

  logic w_empty, w_full, w_push, w_pop;
  assign w_empty = (r_wp == r_rp);
  assign w_full  = ((r_wp - r_rp) == FULL);
  assign w_push  = (r_state == ST_REQ) && mem_ready && !w_load;

  logic              w_act_px, w_starve, w_show, w_last_rep, w_last_idx;
  logic [1:0]        w_bpp_sel, w_rep_max;
  logic [WORD_W-1:0] w_word;
  logic [SHW-1:0]    w_shamt;
  logic [7:0]        w_bits;
  logic [23:0]       w_rgb;

  assign w_bpp_sel  = r_act[2:1];
  assign w_rep_max  = (scale_sh(r_act[4:3]) == 2'd0) ? 2'd0 :
                      (scale_sh(r_act[4:3]) == 2'd1) ? 2'd1 : 2'd3;
  assign w_act_px   = (cx < HA) && (cy < VA) && r_act[0];
  assign w_starve   = w_act_px && !r_stall && !r_have && w_empty;
  assign w_pop      = w_act_px && !r_stall && !r_have && !w_empty;
  assign w_show     = w_act_px && !r_stall && (r_have || !w_empty);
  assign w_word     = r_have ? r_word : r_fifo[r_rp[PTR_W-1:0]];
  assign w_shamt    = SHW'(r_idx) << w_bpp_sel;
  assign w_bits     = 8'(w_word >> w_shamt);
  assign w_last_rep = (r_rep == w_rep_max);
  assign w_last_idx = (r_idx == WSH'((WORD_W >> w_bpp_sel) - 1));

  always_comb begin
    w_rgb = 24'h0;
    case (w_bpp_sel)
      2'd0: w_rgb = {3{{8{w_bits[0]}}}};
      2'd1: w_rgb = {3{{4{w_bits[1:0]}}}};
      2'd2: w_rgb = {3{{2{w_bits[3:0]}}}};
      default: begin
        if (r_act[5])
          w_rgb = {3{w_bits}};
        else
          w_rgb = {w_bits[7:5], w_bits[7:5], w_bits[7:6],
                   w_bits[4:2], w_bits[4:2], w_bits[4:3],
                   {4{w_bits[1:0]}}};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 32'h0;
      r_act  <= 32'h0;
    end else begin
      if (cfg_we)
        r_pend <= {cfg_d[31:7], 1'b0, cfg_d[5:0]};
      if (w_frame_edge)
        r_act <= r_pend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mem_rd <= 1'b0;
      r_addr   <= '0;
      r_remain <= 16'd0;
    end else if (w_load) begin
      r_state  <= ST_IDLE;
      r_mem_rd <= 1'b0;
      r_addr   <= w_load_addr;
      r_remain <= w_wpl_n[15:0];
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_act[0] && (r_remain != 16'd0) && !w_full) begin
            r_state  <= ST_REQ;
            r_mem_rd <= 1'b1;
          end
        end
        default: begin
          if (mem_ready) begin
            r_state  <= ST_IDLE;
            r_mem_rd <= 1'b0;
            r_addr   <= r_addr + ADDR_W'(1);
            r_remain <= r_remain - 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wp[PTR_W-1:0]] <= mem_spo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (w_load) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + (PTR_W+1)'(1);
      if (w_pop)  r_rp <= r_rp + (PTR_W+1)'(1);
    end
  end

  // After a starve the line stays dark until the next trigger re-aligns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_have  <= 1'b0;
      r_stall <= 1'b0;
      r_word  <= '0;
      r_idx   <= '0;
      r_rep   <= 2'd0;
    end else if (w_load) begin
      r_have  <= 1'b0;
      r_stall <= 1'b0;
      r_idx   <= '0;
      r_rep   <= 2'd0;
    end else if (w_act_px && !r_stall) begin
      if (!r_have && w_empty) begin
        r_stall <= 1'b1;
      end else begin
        if (!r_have) begin
          r_word <= w_word;
          r_have <= 1'b1;
        end
        if (w_last_rep) begin
          r_rep <= 2'd0;
          if (w_last_idx) begin
            r_idx  <= '0;
            r_have <= 1'b0;
          end else begin
            r_idx <= r_idx + WSH'(1);
          end
        end else begin
          r_rep <= r_rep + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix      <= 24'h0;
      r_underrun <= 1'b0;
    end else begin
      r_pix <= w_show ? w_rgb : 24'h0;
      if (w_starve)
        r_underrun <= 1'b1;
      else if (cfg_we && cfg_d[6])
        r_underrun <= 1'b0;
    end
  end

  assign cfg_q    = r_act;
  assign mem_rd   = r_mem_rd;
  assign mem_a    = r_addr;
  assign pix_rgb  = r_pix;
  assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// tb_fb_scanout: directed checks of fetch addressing, unpack/colour, config
// shadowing, underrun and asynchronous reset for fb_scanout.
module tb_fb_scanout;

  localparam int HA = 640;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  cx, cy;
  logic        cfg_we;
  logic [31:0] cfg_d, cfg_q;
  logic        mem_rd;
  logic [14:0] mem_a;
  logic        mem_ready;
  logic [31:0] mem_spo;
  logic [23:0] pix_rgb;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:32767];
  bit          mem_en      = 1'b0;
  bit          force_ready = 1'b0;
  logic [14:0] fetch_log [$];
  logic [23:0] line_px [0:HA-1];

  always #5 clk = ~clk;

  fb_scanout dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cx        (cx),
    .cy        (cy),
    .cfg_we    (cfg_we),
    .cfg_d     (cfg_d),
    .cfg_q     (cfg_q),
    .mem_rd    (mem_rd),
    .mem_a     (mem_a),
    .mem_ready (mem_ready),
    .mem_spo   (mem_spo),
    .pix_rgb   (pix_rgb),
    .underrun  (underrun)
  );

  // VRAM model: one-cycle ready pulse per request, driven on the falling edge.
  initial begin
    mem_ready = 1'b0;
    mem_spo   = 32'h0;
    forever begin
      @(negedge clk);
      if (force_ready) begin
        mem_ready = 1'b1;
        mem_spo   = 32'hDEAD_BEEF;
      end else if (mem_en && rst_n && mem_rd && !mem_ready) begin
        mem_ready = 1'b1;
        mem_spo   = mem[mem_a];
        fetch_log.push_back(mem_a);
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i >= 0 && i < fetch_log.size()) return 32'(fetch_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick(input int x, input int y);
    cx = 10'(x);
    cy = 10'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic blank(input int y, input int n);
    for (int i = 0; i < n; i++) tick(700, y);
  endtask

  task automatic trigger(input int y);
    fetch_log.delete();
    tick(HA, y);
    blank(y, 150);
  endtask

  task automatic run_active(input int y);
    for (int x = 0; x < HA; x++) begin
      tick(x, y);
      line_px[x] = pix_rgb;
    end
  endtask

  task automatic cfg_write(input logic [31:0] d, input int y);
    cfg_d  = d;
    cfg_we = 1'b1;
    tick(700, y);
    cfg_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    rst_n  = 1'b0;
    cx     = 10'd700;
    cy     = 10'd0;
    cfg_we = 1'b0;
    cfg_d  = 32'h0;

    // ---- reset state, then reset while a request is outstanding
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_rd",   32'(mem_rd),   32'h0);
    chk("rst_mem_a",    32'(mem_a),    32'h0);
    chk("rst_pix",      32'(pix_rgb),  32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    chk("rst_cfg_q",    cfg_q,         32'h0);
    rst_n = 1'b1;
    blank(523, 2);
    cfg_write(32'h0100_0001, 523);
    trigger(524);
    chk("req_mem_rd", 32'(mem_rd), 32'h1);
    chk("req_mem_a",  32'(mem_a),  32'h100);
    rst_n = 1'b0;
    #2;
    chk("arst_mem_rd",   32'(mem_rd),   32'h0);
    chk("arst_pix",      32'(pix_rgb),  32'h0);
    chk("arst_underrun", 32'(underrun), 32'h0);
    chk("arst_cfg_q",    cfg_q,         32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_ready = 1'b1;
    tick(700, 524);
    force_ready = 1'b0;
    blank(524, 3);
    chk("stray_mem_rd", 32'(mem_rd), 32'h0);
    chk("stray_mem_a",  32'(mem_a),  32'h0);

    // ---- 1 bpp, 1x, base 0x100
    mem_en = 1'b1;
    mem[32'h100] = 32'h0000_0005;
    cfg_write(32'h0100_0001, 523);
    trigger(524);
    run_active(0);
    chk("b1_nwords", 32'(fetch_log.size()), 32'd20);
    chk("b1_first",  log_at(0),  32'h100);
    chk("b1_last",   log_at(19), 32'h113);
    chk("b1_px0", 32'(line_px[0]), 32'hFF_FFFF);
    chk("b1_px1", 32'(line_px[1]), 32'h00_0000);
    chk("b1_px2", 32'(line_px[2]), 32'hFF_FFFF);
    chk("b1_px3", 32'(line_px[3]), 32'h00_0000);
    chk("b1_underrun", 32'(underrun), 32'h0);
    trigger(0);
    chk("b1_line1_addr", log_at(0), 32'h114);

    // ---- 8 bpp, 4x, colour then mono
    mem[0] = 32'h031C_E0FF;
    cfg_write(32'h0000_0017, 523);
    trigger(524);
    run_active(0);
    chk("c8_nwords", 32'(fetch_log.size()), 32'd40);
    chk("c8_first",  log_at(0), 32'h0);
    chk("c8_px0",  32'(line_px[0]),  32'hFF_FFFF);
    chk("c8_px3",  32'(line_px[3]),  32'hFF_FFFF);
    chk("c8_px4",  32'(line_px[4]),  32'hFF_0000);
    chk("c8_px7",  32'(line_px[7]),  32'hFF_0000);
    chk("c8_px8",  32'(line_px[8]),  32'h00_FF00);
    chk("c8_px11", 32'(line_px[11]), 32'h00_FF00);
    chk("c8_px12", 32'(line_px[12]), 32'h00_00FF);
    chk("c8_px15", 32'(line_px[15]), 32'h00_00FF);
    trigger(0);
    chk("c8_line1_addr", log_at(0), 32'h0);
    trigger(1);
    trigger(2);
    chk("c8_line3_addr", log_at(0), 32'h0);
    trigger(3);
    chk("c8_line4_addr", log_at(0), 32'd40);
    cfg_write(32'h0000_0037, 523);
    trigger(524);
    run_active(0);
    chk("m8_px0", 32'(line_px[0]), 32'hFF_FFFF);
    chk("m8_px3", 32'(line_px[3]), 32'hFF_FFFF);
    chk("m8_px4", 32'(line_px[4]), 32'hE0_E0E0);
    chk("m8_px8", 32'(line_px[8]), 32'h1C_1C1C);

    // ---- 2 bpp, 2x: 320 source pixels * 2 bits / 32 = 20 words per line
    mem[0] = 32'h0000_00E4;
    cfg_write(32'h0000_000B, 523);
    trigger(524);
    run_active(0);
    chk("g2_nwords", 32'(fetch_log.size()), 32'd20);
    chk("g2_px0", 32'(line_px[0]), 32'h00_0000);
    chk("g2_px1", 32'(line_px[1]), 32'h00_0000);
    chk("g2_px2", 32'(line_px[2]), 32'h55_5555);
    chk("g2_px3", 32'(line_px[3]), 32'h55_5555);
    chk("g2_px4", 32'(line_px[4]), 32'hAA_AAAA);
    chk("g2_px5", 32'(line_px[5]), 32'hAA_AAAA);
    chk("g2_px6", 32'(line_px[6]), 32'hFF_FFFF);
    chk("g2_px7", 32'(line_px[7]), 32'hFF_FFFF);
    trigger(0);
    chk("g2_line1_addr", log_at(0), 32'h0);
    trigger(1);
    chk("g2_line2_addr", log_at(0), 32'd20);

    // ---- underrun: memory never answers during line 0
    mem[32'h114] = 32'h0000_0006;
    mem_en = 1'b0;
    cfg_write(32'h0100_0001, 523);
    trigger(524);
    run_active(0);
    chk("ur_px0", 32'(line_px[0]), 32'h0);
    chk("ur_px5", 32'(line_px[5]), 32'h0);
    chk("ur_set", 32'(underrun), 32'h1);
    trigger(524);
    chk("ur_sticky", 32'(underrun), 32'h1);
    cfg_write(32'h0100_0041, 524);
    chk("ur_clear", 32'(underrun), 32'h0);
    fetch_log.delete();
    tick(HA, 0);
    mem_en = 1'b1;
    blank(0, 150);
    run_active(1);
    chk("ur_rec_addr", log_at(0), 32'h114);
    chk("ur_rec_px0", 32'(line_px[0]), 32'h00_0000);
    chk("ur_rec_px1", 32'(line_px[1]), 32'hFF_FFFF);
    chk("ur_rec_px2", 32'(line_px[2]), 32'hFF_FFFF);
    chk("ur_rec_px3", 32'(line_px[3]), 32'h00_0000);
    chk("ur_rec_flag", 32'(underrun), 32'h0);

    // ---- base change mid-frame takes effect only at the frame edge
    cfg_write(32'h0200_0001, 100);
    chk("sh_cfg_q_mid", cfg_q, 32'h0100_0001);
    trigger(100);
    chk("sh_line101_addr", log_at(0), 32'h8E4);
    trigger(523);
    chk("sh_cfg_q_523", cfg_q, 32'h0100_0001);
    trigger(524);
    chk("sh_cfg_q_new", cfg_q, 32'h0200_0001);
    chk("sh_line0_addr", log_at(0), 32'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
